// File: rtl/game_pkg.sv
// Shared types and constants for the game random-number path.
// Provides the arbiter state encoding, the LFSR width and the seed guard.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    CHECK = 2'd2,
    GRANT = 2'd3
  } state_t;

  localparam int LFSR_W = 10;
  localparam logic [LFSR_W-1:0] LFSR_LOCKUP = 10'h3FF;

  // An XNOR LFSR never leaves all-ones, so that seed is mapped to zero.
  function automatic logic [LFSR_W-1:0] guard_seed(input logic [LFSR_W-1:0] seed);
    logic [LFSR_W-1:0] guarded;
    if (seed == LFSR_LOCKUP) begin
      guarded = {LFSR_W{1'b0}};
    end else begin
      guarded = seed;
    end
    return guarded;
  endfunction

endpackage

// File: rtl/lfsr10_step.sv
// 10-bit XNOR LFSR: taps 0 and 3 feed bit 9; steps only when enabled.
// Load has priority over step; reset clears the register to zero.
module lfsr10_step
  import game_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_load_data,
  output logic [LFSR_W-1:0] o_state
);

  logic [LFSR_W-1:0] r_ps;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ps <= {LFSR_W{1'b0}};
    end else if (i_load) begin
      r_ps <= i_load_data;
    end else if (i_en) begin
      r_ps <= {r_ps[0] ~^ r_ps[3], r_ps[LFSR_W-1:1]};
    end else begin
      r_ps <= r_ps;
    end
  end

  assign o_state = r_ps;

endmodule

// File: rtl/lfsr_request_arbiter.sv
// Round-robin arbiter sharing one LFSR between game requesters.
// Each grant rejection-samples LFSR values into 0..LIMIT, falling back after MAX_TRIES.
module lfsr_request_arbiter
  import game_pkg::*;
#(
  parameter int                NUM_REQ   = 3,
  parameter logic [LFSR_W-1:0] LIMIT     = 10'd479,
  parameter int                MAX_TRIES = 8,
  parameter logic [LFSR_W-1:0] FALLBACK  = 10'd240
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_ack,
  output logic [LFSR_W-1:0]  o_value,
  input  logic               i_seed_load,
  input  logic [LFSR_W-1:0]  i_seed,
  output logic               o_busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] MAX_TRIES_C = 4'(MAX_TRIES);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [IDX_W-1:0]   r_winner;
  logic [IDX_W-1:0]   r_last;
  logic [3:0]         r_tries;
  logic [LFSR_W-1:0]  r_value;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_busy;
  logic               w_lfsr_en;
  logic               w_lfsr_load;
  logic [LFSR_W-1:0]  w_ps;
  logic [LFSR_W-1:0]  w_seed_guarded;
  logic [IDX_W-1:0]   w_pick;
  logic [NUM_REQ-1:0] w_winner_oh;

  // First set request scanning upward from the requester after the last winner.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = {IDX_W{1'b0}};
    found = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_seed_guarded = guard_seed(i_seed);
  assign w_pick         = rr_pick(i_req, r_last);
  assign w_winner_oh    = NUM_REQ'(1) << r_winner;

  lfsr10_step u_lfsr (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (w_lfsr_en),
    .i_load      (w_lfsr_load),
    .i_load_data (w_seed_guarded),
    .o_state     (w_ps)
  );

  always_comb begin
    w_next_state = r_state;
    w_lfsr_en    = 1'b0;
    w_lfsr_load  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_seed_load) begin
          w_lfsr_load  = 1'b1;
          w_next_state = IDLE;
        end else if (|i_req) begin
          w_next_state = STEP;
        end else begin
          w_next_state = IDLE;
        end
      end
      STEP: begin
        w_lfsr_en    = 1'b1;
        w_next_state = CHECK;
      end
      CHECK: begin
        if (w_ps <= LIMIT) begin
          w_next_state = GRANT;
        end else if (r_tries == MAX_TRIES_C) begin
          w_next_state = GRANT;
        end else begin
          w_next_state = STEP;
        end
      end
      GRANT: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // ack and busy are registered from the next state so they align with GRANT/non-IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_winner <= {IDX_W{1'b0}};
      r_last   <= LAST_INIT;
      r_tries  <= 4'd0;
      r_value  <= {LFSR_W{1'b0}};
      r_ack    <= {NUM_REQ{1'b0}};
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != IDLE);
      r_ack   <= (w_next_state == GRANT) ? w_winner_oh : {NUM_REQ{1'b0}};
      case (r_state)
        IDLE: begin
          if (!i_seed_load && (|i_req)) begin
            r_winner <= w_pick;
            r_tries  <= 4'd0;
          end
        end
        STEP: begin
          r_tries <= r_tries + 4'd1;
        end
        CHECK: begin
          if (w_ps <= LIMIT) begin
            r_value <= w_ps;
          end else if (r_tries == MAX_TRIES_C) begin
            r_value <= FALLBACK;
          end
        end
        GRANT: begin
          r_last <= r_winner;
        end
        default: begin
          r_last <= r_last;
        end
      endcase
    end
  end

  assign o_ack   = r_ack;
  assign o_value = r_value;
  assign o_busy  = r_busy;

endmodule

// File: tb/tb_lfsr_request_arbiter.sv
// Directed and randomised self-checking bench for lfsr_request_arbiter.
// A second instance with LIMIT=1023 covers the no-rejection seed case.
module tb_lfsr_request_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic       seed_load = 1'b0;
  logic [9:0] seed = 10'd0;
  logic [2:0] ack;
  logic [9:0] value;
  logic       busy;

  logic [2:0] req_l = 3'b000;
  logic       seed_load_l = 1'b0;
  logic [9:0] seed_l = 10'd0;
  logic [2:0] ack_l;
  logic [9:0] value_l;
  logic       busy_l;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lfsr_request_arbiter dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .o_ack(ack), .o_value(value),
    .i_seed_load(seed_load), .i_seed(seed), .o_busy(busy)
  );

  lfsr_request_arbiter #(.LIMIT(10'd1023)) dut_l (
    .i_clk(clk), .i_rst(rst), .i_req(req_l), .o_ack(ack_l), .o_value(value_l),
    .i_seed_load(seed_load_l), .i_seed(seed_l), .o_busy(busy_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [9:0] lfsr_next(input logic [9:0] p);
    return {~(p[0] ^ p[3]), p[9:1]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = 3'b000; req_l = 3'b000; seed_load = 1'b0; seed_load_l = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // lat = index of the posedge (0 = first one after the call) after which ack was seen.
  task automatic wait_ack(input bit use_l, output int lat, output logic [2:0] a, output logic [9:0] v);
    lat = -1; a = 3'b000; v = 10'd0;
    for (int e = 0; e < 200; e++) begin
      @(posedge clk);
      @(negedge clk);
      a = use_l ? ack_l : ack;
      v = use_l ? value_l : value;
      if (a != 3'b000) begin
        lat = e;
        break;
      end
    end
    if (lat < 0) check("ack_timeout", 32'd0, 32'd1);
  endtask

  int         lat;
  logic [2:0] a;
  logic [9:0] v;
  logic [2:0] exp_ack [4];
  logic [9:0] exp_val [4];
  int         exp_lat [4];

  initial begin
    exp_ack[0] = 3'b001; exp_val[0] = 10'd240; exp_lat[0] = 16;
    exp_ack[1] = 3'b010; exp_val[1] = 10'd254; exp_lat[1] = 3;
    exp_ack[2] = 3'b100; exp_val[2] = 10'h07F; exp_lat[2] = 3;
    exp_ack[3] = 3'b001; exp_val[3] = 10'h0F1; exp_lat[3] = 13;

    do_reset();
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_value", 32'(value), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // Eight rejections from ps=0, then fallback.
    req = 3'b001;
    @(posedge clk); @(negedge clk);
    check("busy_in_step", 32'(busy), 32'd1);
    wait_ack(1'b0, lat, a, v);
    req = 3'b000;
    check("fb_lat", 32'(lat), 32'd15);
    check("fb_ack", 32'(a), 32'b001);
    check("fb_value", 32'(v), 32'd240);
    @(posedge clk); @(negedge clk);
    check("ack_single_pulse", 32'(ack), 32'd0);
    check("idle_after_grant", 32'(busy), 32'd0);

    // Next step 0x1FC -> 0x0FE, accepted first try.
    req = 3'b010;
    wait_ack(1'b0, lat, a, v);
    req = 3'b000;
    check("best_lat", 32'(lat), 32'd2);
    check("best_ack", 32'(a), 32'b010);
    check("best_value", 32'(v), 32'd254);

    // All requesters held: round-robin 0,1,2,0.
    do_reset();
    req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      wait_ack(1'b0, lat, a, v);
      check($sformatf("rr%0d_lat", g), 32'(lat), 32'(exp_lat[g]));
      check($sformatf("rr%0d_ack", g), 32'(a), 32'(exp_ack[g]));
      check($sformatf("rr%0d_value", g), 32'(v), 32'(exp_val[g]));
    end
    req = 3'b000;
    @(posedge clk); @(negedge clk);
    check("rr_idle", 32'(busy), 32'd0);

    // Lock-up seed together with a request: seed wins, request served next cycle.
    seed_load = 1'b1; seed = 10'h3FF; req = 3'b001;
    @(posedge clk); @(negedge clk);
    seed_load = 1'b0;
    check("seed_stays_idle", 32'(busy), 32'd0);
    wait_ack(1'b0, lat, a, v);
    req = 3'b000;
    check("seed_lock_lat", 32'(lat), 32'd16);
    check("seed_lock_value", 32'(v), 32'd240);

    // LIMIT=1023 instance: seed 0x0FE gives 0x07F first.
    seed_load_l = 1'b1; seed_l = 10'h0FE;
    @(negedge clk);
    seed_load_l = 1'b0; req_l = 3'b001;
    wait_ack(1'b1, lat, a, v);
    req_l = 3'b000;
    check("l_lat", 32'(lat), 32'd2);
    check("l_ack", 32'(a), 32'b001);
    check("l_value", 32'(v), 32'h07F);

    // seed_load while in STEP is ignored.
    do_reset();
    req = 3'b001;
    @(posedge clk); @(negedge clk);
    seed_load = 1'b1; seed = 10'h155;
    @(posedge clk); @(negedge clk);
    seed_load = 1'b0;
    wait_ack(1'b0, lat, a, v);
    req = 3'b000;
    check("busy_seed_lat", 32'(lat), 32'd14);
    check("busy_seed_value", 32'(v), 32'd240);

    // Reset during CHECK aborts with no ack, then restart from ps=0.
    @(negedge clk);
    req = 3'b010;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst = 1'b1; req = 3'b000;
    #1;
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_value", 32'(value), 32'd0);
    repeat (2) @(negedge clk);
    check("midrst_no_ack", 32'(ack), 32'd0);
    rst = 1'b0;
    req = 3'b001;
    wait_ack(1'b0, lat, a, v);
    req = 3'b000;
    check("restart_lat", 32'(lat), 32'd16);
    check("restart_ack", 32'(a), 32'b001);
    check("restart_value", 32'(v), 32'd240);

    // Random traffic against a value model and starvation bound.
    do_reset();
    begin
      logic [9:0] m_ps;
      logic [9:0] m_val;
      int         waits [3];
      m_ps = 10'd0;
      for (int i = 0; i < 3; i++) waits[i] = 0;
      for (int c = 0; c < 10000; c++) begin
        @(posedge clk); @(negedge clk);
        check("ack_not_multihot", 32'($countones(ack) <= 1), 32'd1);
        if (ack != 3'b000) begin
          m_val = 10'd240;
          for (int t = 0; t < 8; t++) begin
            m_ps = lfsr_next(m_ps);
            if (m_ps <= 10'd479) begin
              m_val = m_ps;
              break;
            end
          end
          check("rand_value", 32'(value), 32'(m_val));
          check("rand_in_range", 32'(value <= 10'd479), 32'd1);
          for (int i = 0; i < 3; i++) begin
            if (ack[i]) waits[i] = 0;
            else if (req[i]) waits[i]++;
            check($sformatf("starve%0d", i), 32'(waits[i] <= 3), 32'd1);
          end
        end
        for (int i = 0; i < 3; i++) begin
          if (ack[i]) req[i] = 1'b0;
          else if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
        end
      end
      req = 3'b000;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lfsr_request_arbiter.md
Name: lfsr_request_arbiter

Overview:
- Shares one 10-bit XNOR LFSR between NUM_REQ game requesters, such as the pipe-gap spawner and the obstacle-height picker.
- Arbitrates requests round-robin and advances the LFSR only on demand.
- Rejection-samples each value into the range 0..LIMIT; after MAX_TRIES rejections it returns a fixed FALLBACK value.
- Sits between the game FSMs and the random source. Supports a seed load, for example from a free-running counter sampled at the start key.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- LIMIT, 10'd479, largest acceptable value, inclusive (e.g. screen rows minus gap).
- MAX_TRIES, 8, LFSR steps per request before fallback (1..15).
- FALLBACK, 10'd240, value returned when all tries are rejected; must be <= LIMIT.

Ports:
- Clock, in, 1, system clock; all state changes on posedge.
- Reset, in, 1, asynchronous, active-high reset.
- req, in, NUM_REQ, level request per requester; held high until its ack.
- ack, out, NUM_REQ, one-cycle grant pulse; one-hot or zero.
- value, out, 10, random value; valid during the ack cycle and held until the next grant.
- seed_load, in, 1, load seed into the LFSR (honoured in IDLE only).
- seed, in, 10, seed value.
- busy, out, 1, high in any state other than IDLE.

Behaviour:
- LFSR (ps[9:0]):
  - Step rule: ps <= {ps[0] XNOR ps[3], ps[9:1]}.
  - Reset value is 0; ps advances only in STEP.
  - All-ones is the lock-up state. A seed of 10'h3FF loads 10'h000 instead.
- Reset (async, any state): state=IDLE, ps=0, ack=0, value=0, busy=0, tries=0, last=NUM_REQ-1 (so req[0] has top priority first). An in-flight request is aborted with no ack.
- States IDLE, STEP, CHECK, GRANT:
  - IDLE:
    - If seed_load: ps <= guarded seed; stay in IDLE. Seed has priority over req in the same cycle; held req is served next cycle.
    - Else if |req: winner = first set bit scanning last+1, last+2, … (mod NUM_REQ); latch winner; tries=0; go to STEP.
  - STEP: advance ps; tries++; go to CHECK.
  - CHECK:
    - If ps <= LIMIT: value <= ps; go to GRANT.
    - Else if tries == MAX_TRIES: value <= FALLBACK; go to GRANT.
    - Else go to STEP.
  - GRANT: ack[winner]=1 for exactly this cycle; last <= winner; go to IDLE.
- Timing:
  - Latency with n tries: a req seen at IDLE edge k gives ack high in the cycle after edge k+2n. Best case (n=1) is the cycle after edge k+2.
  - Back-to-back grants are at least 4 cycles apart.
  - A requester must deassert req in the cycle after its ack. A req still high there starts a new request.
- Boundary conditions:
  - A req dropped mid-service still completes and pulses ack. The value is consumed and the LFSR is advanced.
  - seed_load while busy is ignored (not queued).
  - ack and busy are registered (decoded from state).
  - value is never > LIMIT.
  - LIMIT=1023 never triggers rejection, except that FALLBACK is still used if MAX_TRIES is hit, which is unreachable.

Decomposition:
- Shared package (game_pkg): state enum typedef {IDLE, STEP, CHECK, GRANT}; LFSR width constant 10; LFSR_LOCKUP = 10'h3FF.
- One sub-module, lfsr10_step: 10-bit XNOR LFSR with enable, load and load data, async active-high reset to 0.
- The round-robin pick stays inline as a combinational function.

Test Plan:
- Reset, then req=3'b001 (defaults): LFSR steps 0x200, 0x300, 0x380, 0x3C0, 0x3E0, 0x3F0, 0x3F8, 0x1FC are all rejected. Expect ack=3'b001 after 16 post-request edges and value=240 (fallback).
- Continue with req=3'b010: next step gives 0x0FE. Expect ack=3'b010 with value=254 after one try, best-case latency.
- req=3'b111 held after reset: grants in order 0, 1, 2, then 0 again. Each grant is a single-cycle one-hot pulse at least 4 cycles after the previous one.
- seed_load=1 with seed=10'h3FF in IDLE: ps=0. The next request reproduces the reset sequence (value=240). With seed=10'h0FE and LIMIT=1023, the first value is 10'h07F.
- seed_load asserted during STEP: ignored, and the sequence is unchanged. Reset asserted mid-CHECK: ack stays 0, outputs clear immediately, and the next request restarts from ps=0.
- Random req stimulus over 10k cycles: value <= LIMIT at every ack; ack is never multi-hot; no requester is starved longer than NUM_REQ grants.
